// File: rtl/seg7_updown_decoder.sv
// rtl/seg7_updown_decoder.sv - 7-segment up/down stream decoder with lock tracking and error count.
// Optional build macro SEG7_ACTIVE_HIGH_EN: treat seg_i as active-high (inverted before decode).
module seg7_updown_decoder #(
  parameter int ERR_W       = 16,
  parameter int LOSS_THRESH = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [6:0]       seg_i,
  input  logic             seg_valid_i,
  input  logic             err_clr_i,
  output logic [3:0]       digit_o,
  output logic             dir_o,
  output logic             locked_o,
  output logic             step_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  localparam logic [1:0] ST_ACQUIRE = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [6:0] AMBIG  = 7'b0000001;
  localparam logic [3:0] THRESH = 4'(LOSS_THRESH);

  function automatic logic [6:0] code(input logic [3:0] v);
    case (v)
      4'd0:  code = 7'b0000001;
      4'd1:  code = 7'b1001111;
      4'd2:  code = 7'b0010010;
      4'd3:  code = 7'b0000110;
      4'd4:  code = 7'b1001100;
      4'd5:  code = 7'b0100100;
      4'd6:  code = 7'b0100000;
      4'd7:  code = 7'b0001111;
      4'd8:  code = 7'b0000000;
      4'd9:  code = 7'b0000100;
      4'd10: code = 7'b0001001;
      4'd11: code = 7'b1100000;
      4'd12: code = 7'b0110001;
      4'd13: code = 7'b0000001;
      4'd14: code = 7'b0110000;
      default: code = 7'b0111000;
    endcase
  endfunction

  logic [1:0] state;
  logic [3:0] streak;
  logic [3:0] streak_nxt;
  logic [6:0] seg_cmp;
  logic       acq_ok;
  logic [3:0] acq_val;
  logic       is_up;
  logic       is_down;
  logic       is_hold;

`ifdef SEG7_ACTIVE_HIGH_EN
  assign seg_cmp = ~seg_i;
`else
  assign seg_cmp = seg_i;
`endif

  // Absolute decode is only trusted for unambiguous patterns while acquiring.
  always_comb begin
    acq_ok  = 1'b0;
    acq_val = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (code(4'(i)) == seg_cmp) begin
        acq_ok  = 1'b1;
        acq_val = 4'(i);
      end
    end
    if (seg_cmp == AMBIG) acq_ok = 1'b0;
  end

  assign is_up      = (seg_cmp == code(digit_o + 4'd1));
  assign is_down    = (seg_cmp == code(digit_o - 4'd1));
  assign is_hold    = (seg_cmp == code(digit_o));
  assign streak_nxt = streak + 4'd1;
  assign locked_o   = (state == ST_LOCKED);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_ACQUIRE;
      digit_o   <= 4'd0;
      dir_o     <= 1'b1;
      step_o    <= 1'b0;
      err_o     <= 1'b0;
      err_cnt_o <= '0;
      streak    <= 4'd0;
    end else begin
      step_o <= 1'b0;
      err_o  <= 1'b0;
      if (err_clr_i) err_cnt_o <= '0;
      if (seg_valid_i) begin
        case (state)
          ST_ACQUIRE: begin
            if (acq_ok) begin
              digit_o <= acq_val;
              state   <= ST_CONFIRM;
            end
          end
          ST_CONFIRM: begin
            if (is_up || is_down) begin
              digit_o <= is_up ? digit_o + 4'd1 : digit_o - 4'd1;
              dir_o   <= is_up;
              state   <= ST_LOCKED;
            end else if (!is_hold) begin
              state <= ST_ACQUIRE;
            end
          end
          ST_LOCKED: begin
            if (is_up || is_down) begin
              digit_o <= is_up ? digit_o + 4'd1 : digit_o - 4'd1;
              dir_o   <= is_up;
              step_o  <= 1'b1;
              streak  <= 4'd0;
            end else if (is_hold) begin
              streak <= 4'd0;
            end else begin
              err_o <= 1'b1;
              if (!err_clr_i && err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_W'(1);
              if (streak_nxt >= THRESH) begin
                state  <= ST_ACQUIRE;
                streak <= 4'd0;
              end else begin
                streak <= streak_nxt;
              end
            end
          end
          default: state <= ST_ACQUIRE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_updown_decoder.sv
// tb/tb_seg7_updown_decoder.sv - directed checks of seg7_updown_decoder decode, lock, error and reset paths.
module tb_seg7_updown_decoder;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [6:0]  seg_i = 7'h7f;
  logic        seg_valid_i = 1'b0;
  logic        err_clr_i = 1'b0;
  logic [3:0]  digit_o;
  logic        dir_o;
  logic        locked_o;
  logic        step_o;
  logic        err_o;
  logic [15:0] err_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  seg7_updown_decoder #(.ERR_W(16), .LOSS_THRESH(3)) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .seg_i       (seg_i),
    .seg_valid_i (seg_valid_i),
    .err_clr_i   (err_clr_i),
    .digit_o     (digit_o),
    .dir_o       (dir_o),
    .locked_o    (locked_o),
    .step_o      (step_o),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Patterns below are written active-low; the active-high build sees them inverted.
  function automatic logic [6:0] bus(input logic [6:0] p);
`ifdef SEG7_ACTIVE_HIGH_EN
    bus = ~p;
`else
    bus = p;
`endif
  endfunction

  task automatic sample(input logic [6:0] p, input logic clr);
    @(negedge wb_clk_i);
    seg_i       = bus(p);
    seg_valid_i = 1'b1;
    err_clr_i   = clr;
    @(posedge wb_clk_i);
    #1;
    seg_valid_i = 1'b0;
    err_clr_i   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_digit", digit_o, 0);
    check("rst_dir", dir_o, 1);
    check("rst_locked", locked_o, 0);
    check("rst_step", step_o, 0);
    check("rst_err", err_o, 0);
    check("rst_cnt", err_cnt_o, 0);

    sample(7'b1001111, 0);
    check("acq1_locked", locked_o, 0);
    check("acq1_step", step_o, 0);
    check("acq1_digit", digit_o, 1);
    sample(7'b1001111, 0);
    check("confirm_hold_locked", locked_o, 0);
    sample(7'b0010010, 0);
    check("lock2_locked", locked_o, 1);
    check("lock2_digit", digit_o, 2);
    check("lock2_dir", dir_o, 1);
    check("lock2_step", step_o, 0);

    do_reset();
    sample(7'b1100000, 0);
    sample(7'b0110001, 0);
    check("at12_locked", locked_o, 1);
    check("at12_dir", dir_o, 1);
    sample(7'b0000001, 0);
    check("amb_up_digit", digit_o, 13);
    check("amb_up_step", step_o, 1);
    check("amb_up_dir", dir_o, 1);
    sample(7'b0110001, 0);
    check("down12_digit", digit_o, 12);
    check("down12_dir", dir_o, 0);
    check("down12_step", step_o, 1);
    @(posedge wb_clk_i); #1;
    check("idle_step", step_o, 0);

    sample(7'b0000001, 0);
    sample(7'b0110000, 0);
    sample(7'b0111000, 0);
    check("at15_digit", digit_o, 15);
    sample(7'b0000001, 0);
    check("wrap_up_digit", digit_o, 0);
    check("wrap_up_dir", dir_o, 1);
    sample(7'b0111000, 0);
    check("wrap_dn_digit", digit_o, 15);
    check("wrap_dn_dir", dir_o, 0);

    do_reset();
    sample(7'b1001100, 0);
    sample(7'b0100100, 0);
    check("at5_locked", locked_o, 1);
    for (int i = 1; i <= 3; i++) begin
      sample(7'b1111111, 0);
      check($sformatf("miss%0d_err", i), err_o, 1);
      check($sformatf("miss%0d_cnt", i), err_cnt_o, i);
      check($sformatf("miss%0d_locked", i), locked_o, (i < 3) ? 1 : 0);
      check($sformatf("miss%0d_digit", i), digit_o, 5);
    end
    @(posedge wb_clk_i); #1;
    check("idle_err", err_o, 0);

    do_reset();
    sample(7'b0000001, 0);
    check("acq_amb_locked", locked_o, 0);
    check("acq_amb_digit", digit_o, 0);
    sample(7'b1111111, 0);
    check("acq_inv_err", err_o, 0);
    check("acq_inv_cnt", err_cnt_o, 0);
    sample(7'b0001111, 0);
    sample(7'b0000000, 0);
    check("at8_locked", locked_o, 1);
    check("at8_digit", digit_o, 8);
    sample(7'b1111111, 0);
    check("miss_a_cnt", err_cnt_o, 1);
    sample(7'b1111111, 1);
    check("clr_miss_cnt", err_cnt_o, 0);
    check("clr_miss_locked", locked_o, 1);
    sample(7'b0000000, 0);
    sample(7'b1111111, 0);
    check("streak_reset_locked", locked_o, 1);
    check("streak_reset_cnt", err_cnt_o, 1);
    sample(7'b0000100, 0);
    check("at9_digit", digit_o, 9);
    check("at9_step", step_o, 1);

    #2;
    wb_rst_i = 1'b1;
    #1;
    check("async_rst_digit", digit_o, 0);
    check("async_rst_locked", locked_o, 0);
    check("async_rst_cnt", err_cnt_o, 0);
    check("async_rst_step", step_o, 0);
    check("async_rst_dir", dir_o, 1);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    sample(7'b0000100, 0);
    check("relock_first_locked", locked_o, 0);
    sample(7'b0001001, 0);
    check("relock_locked", locked_o, 1);
    check("relock_digit", digit_o, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
